// File: rtl/alu_reg_file_if.sv
// Host-side register bus of alu_reg_file: write strobe, combinational read port
// and engine status.
interface alu_reg_file_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32
);
    // Handshake: write_en is a one-cycle strobe that is always taken (no backpressure).
    // An operation is launched by writing CTRL with GO while busy=0. busy stays high
    // until the commit edge. done_pulse is high for the single cycle after that edge,
    // and in that same cycle read_data already shows the committed value.
    logic                write_en;
    logic [ADDR_W-1:0]   write_addr;
    logic [DATA_W-1:0]   write_data;
    logic [DATA_W/8-1:0] write_strb;
    logic [ADDR_W-1:0]   read_addr;
    logic [DATA_W-1:0]   read_data;
    logic                busy;
    logic                done_pulse;

    modport master (
        output write_en, write_addr, write_data, write_strb, read_addr,
        input  read_data, busy, done_pulse
    );
    modport slave (
        input  write_en, write_addr, write_data, write_strb, read_addr,
        output read_data, busy, done_pulse
    );
endinterface

// File: rtl/alu_reg_file.sv
// Register file with an attached ALU / memory-register engine. Operations are
// launched by CTRL.GO and sequenced by an IDLE/EXEC/MUL state machine.
module alu_reg_file #(
    parameter int DATA_W   = 32,
    parameter int NUM_REGS = 16,
    parameter int OPND_W   = 8,
    parameter int ADDR_W   = 32
) (
    input  logic          clk,
    input  logic          reset_n,
    alu_reg_file_if.slave bus,
    output logic [1:0]    dbg_state
);
    localparam int IDX_W  = $clog2(NUM_REGS);
    localparam int STRB_W = DATA_W / 8;
    localparam int PROD_W = 2 * OPND_W;
    localparam int CNT_W  = $clog2(OPND_W + 1);

    localparam logic [IDX_W-1:0] IDX_OPA    = IDX_W'(0);
    localparam logic [IDX_W-1:0] IDX_OPB    = IDX_W'(1);
    localparam logic [IDX_W-1:0] IDX_CTRL   = IDX_W'(2);
    localparam logic [IDX_W-1:0] IDX_RESULT = IDX_W'(3);
    localparam logic [IDX_W-1:0] IDX_MSEL   = IDX_W'(4);
    localparam logic [IDX_W-1:0] IDX_STATUS = IDX_W'(5);

    typedef enum logic [1:0] {S_IDLE = 2'd0, S_EXEC = 2'd1, S_MUL = 2'd2} state_t;
    state_t state_q, state_d;

    logic [OPND_W-1:0] opa_q, opb_q, lat_a, lat_b, mplier_q;
    logic [2:0]        opcode_q, lat_op, next_op;
    logic [DATA_W-1:0] result_q, msel_q;
    logic              done_q, err_msel_q, wr_drop_q, done_pulse_q;
    logic [DATA_W-1:0] mem_q [6:NUM_REGS-1];
    logic              lat_msel_ok;
    logic [IDX_W-1:0]  lat_midx;
    logic [PROD_W-1:0] acc_q, mcand_q, acc_next;
    logic [CNT_W-1:0]  cnt_q;

    logic [IDX_W-1:0]  wr_idx, rd_idx;
    logic              busy, wr_valid, wr_protected, drop, host_ok, go, sts_clr, msel_ok;
    logic [DATA_W-1:0] wr_cur, wr_merged, read_val;
    logic              res_we, mem_we, set_err, set_done;
    logic [DATA_W-1:0] res_val, mem_val, mem_cur, a_ext, b_ext;
    logic              unused_addr_bits;

    assign wr_idx = bus.write_addr[IDX_W+1:2];
    assign rd_idx = bus.read_addr[IDX_W+1:2];
    assign busy   = (state_q != S_IDLE);
    assign unused_addr_bits = ^{bus.write_addr[ADDR_W-1:IDX_W+2], bus.write_addr[1:0],
                                bus.read_addr[ADDR_W-1:IDX_W+2], bus.read_addr[1:0]};

    function automatic logic [DATA_W-1:0] reg_value(input logic [IDX_W-1:0] idx);
        logic [DATA_W-1:0] v;
        v = '0;
        if (int'(idx) < NUM_REGS) begin
            case (idx)
                IDX_OPA:    v = DATA_W'(opa_q);
                IDX_OPB:    v = DATA_W'(opb_q);
                IDX_CTRL:   v = DATA_W'(opcode_q);
                IDX_RESULT: v = result_q;
                IDX_MSEL:   v = msel_q;
                IDX_STATUS: v = DATA_W'({wr_drop_q, err_msel_q, done_q, busy});
                default:    v = mem_q[idx];
            endcase
        end
        return v;
    endfunction

    always_comb begin
        read_val = reg_value(rd_idx);
        wr_cur   = reg_value(wr_idx);
        for (int b = 0; b < STRB_W; b++) begin
            wr_merged[8*b +: 8] = bus.write_strb[b] ? bus.write_data[8*b +: 8] : wr_cur[8*b +: 8];
        end
    end

    // Operand, control and MSEL writes are locked out while the engine runs.
    assign wr_valid     = bus.write_en && (int'(wr_idx) < NUM_REGS);
    assign wr_protected = (wr_idx == IDX_OPA) || (wr_idx == IDX_OPB) ||
                          (wr_idx == IDX_CTRL) || (wr_idx == IDX_MSEL);
    assign drop    = wr_valid && busy && wr_protected;
    assign host_ok = wr_valid && !(busy && wr_protected);
    assign go      = host_ok && (wr_idx == IDX_CTRL) && bus.write_strb[1] && bus.write_data[8];
    assign next_op = wr_merged[2:0];
    assign sts_clr = host_ok && (wr_idx == IDX_STATUS) && bus.write_strb[0];
    assign msel_ok = (msel_q >= DATA_W'(6)) && (msel_q < DATA_W'(NUM_REGS));

    always_comb begin
        res_we   = 1'b0;
        res_val  = result_q;
        mem_we   = 1'b0;
        mem_val  = '0;
        set_err  = 1'b0;
        set_done = 1'b0;
        a_ext    = DATA_W'(lat_a);
        b_ext    = DATA_W'(lat_b);
        mem_cur  = lat_msel_ok ? mem_q[lat_midx] : '0;
        acc_next = acc_q + (mplier_q[0] ? mcand_q : '0);
        if (state_q == S_EXEC) begin
            set_done = 1'b1;
            case (lat_op)
                3'd0: begin res_we = 1'b1; res_val = a_ext + b_ext; end
                3'd1: begin res_we = 1'b1; res_val = a_ext - b_ext; end
                3'd2: begin res_we = 1'b1; res_val = a_ext & b_ext; end
                3'd4: begin mem_we = lat_msel_ok; mem_val = mem_cur + result_q; set_err = !lat_msel_ok; end
                3'd5: begin mem_we = lat_msel_ok; mem_val = mem_cur - result_q; set_err = !lat_msel_ok; end
                3'd6: begin res_we = lat_msel_ok; res_val = mem_cur; set_err = !lat_msel_ok; end
                3'd7: begin mem_we = lat_msel_ok; mem_val = '0; set_err = !lat_msel_ok; end
                default: ;
            endcase
        end else if (state_q == S_MUL && cnt_q == CNT_W'(1)) begin
            set_done = 1'b1;
            res_we   = 1'b1;
            res_val  = DATA_W'(acc_next);
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (go) state_d = (next_op == 3'd3) ? S_MUL : S_EXEC;
            S_EXEC:  state_d = S_IDLE;
            S_MUL:   if (cnt_q == CNT_W'(1)) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) state_q <= S_IDLE;
        else          state_q <= state_d;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            opa_q <= '0; opb_q <= '0; opcode_q <= '0; result_q <= '0; msel_q <= '0;
            done_q <= 1'b0; err_msel_q <= 1'b0; wr_drop_q <= 1'b0; done_pulse_q <= 1'b0;
            lat_a <= '0; lat_b <= '0; lat_op <= '0; lat_msel_ok <= 1'b0; lat_midx <= '0;
            acc_q <= '0; mcand_q <= '0; mplier_q <= '0; cnt_q <= '0;
        end else begin
            if (host_ok && wr_idx == IDX_OPA)  opa_q    <= wr_merged[OPND_W-1:0];
            if (host_ok && wr_idx == IDX_OPB)  opb_q    <= wr_merged[OPND_W-1:0];
            if (host_ok && wr_idx == IDX_CTRL) opcode_q <= wr_merged[2:0];
            if (host_ok && wr_idx == IDX_MSEL) msel_q   <= wr_merged;
            if (res_we) result_q <= res_val;
            // New events win over a same-edge write-1-to-clear.
            done_q       <= set_done | (done_q     & ~(sts_clr & bus.write_data[1]));
            err_msel_q   <= set_err  | (err_msel_q & ~(sts_clr & bus.write_data[2]));
            wr_drop_q    <= drop     | (wr_drop_q  & ~(sts_clr & bus.write_data[3]));
            done_pulse_q <= set_done;
            // Operands are captured from the pre-edge register values at GO.
            if (go) begin
                lat_a       <= opa_q;
                lat_b       <= opb_q;
                lat_op      <= next_op;
                lat_msel_ok <= msel_ok;
                lat_midx    <= msel_q[IDX_W-1:0];
                acc_q       <= '0;
                mcand_q     <= PROD_W'(opa_q);
                mplier_q    <= opb_q;
                cnt_q       <= CNT_W'(OPND_W);
            end else if (state_q == S_MUL) begin
                acc_q    <= acc_next;
                mcand_q  <= mcand_q << 1;
                mplier_q <= mplier_q >> 1;
                cnt_q    <= cnt_q - CNT_W'(1);
            end
        end
    end

    // An engine commit overrides a host write to the same MEM register.
    for (genvar g = 6; g < NUM_REGS; g++) begin : g_mem
        always_ff @(posedge clk) begin
            if (!reset_n)                                     mem_q[g] <= '0;
            else if (mem_we && lat_midx == IDX_W'(g))          mem_q[g] <= mem_val;
            else if (host_ok && wr_idx == IDX_W'(g))           mem_q[g] <= wr_merged;
        end
    end

    always_comb bus.read_data = read_val;
    assign bus.busy       = busy;
    assign bus.done_pulse = done_pulse_q;
    assign dbg_state      = state_q;
endmodule
